// File: rtl/hub75_scan_gen.sv
// hub75_scan_gen: reads RGB565 pixels from the frame-buffer RAM and drives a 1/32-scan HUB75
// chain with 5-plane binary-coded modulation (shift, latch, show per plane per row).
module hub75_scan_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned BASE_ON = 8,
    parameter int unsigned PLANES  = 5
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        enable,
    input  logic [9:0]  pixels_per_row,
    output logic [14:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    output logic        hub_r1,
    output logic        hub_g1,
    output logic        hub_b1,
    output logic        hub_r2,
    output logic        hub_g2,
    output logic        hub_b2,
    output logic [4:0]  hub_addr,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle, StFetchT, StFetchB, StShiftL, StShiftH, StLatch, StShow
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [2:0]  plane_q, plane_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  ppr_q, ppr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] top_q;
    logic [15:0] state_len;
    logic [9:0]  ppr_clamp;
    logic        last_cyc;
    logic        last_col;
    logic [3:0]  r_idx, g_idx, b_idx;

    // Chain length clamped to 1..512 so col never addresses past column 511.
    always_comb begin
        ppr_clamp = pixels_per_row;
        if (pixels_per_row == 10'd0) begin
            ppr_clamp = 10'd1;
        end else if (pixels_per_row > 10'd512) begin
            ppr_clamp = 10'd512;
        end
    end

    // Per-state dwell length, plane bit indices and end-of-state flags.
    always_comb begin
        state_len = (state_q == StShow) ? 16'(BASE_ON << plane_q) : 16'(CLK_DIV);
        last_cyc  = (cnt_q == state_len - 16'd1);
        last_col  = (col_q + 10'd1 == ppr_q);
        r_idx     = 4'd11 + {1'b0, plane_q};
        g_idx     = 4'd6 + {1'b0, plane_q};
        b_idx     = {1'b0, plane_q};
    end

    // State and counter registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
            row_q   <= 5'd0;
            plane_q <= 3'd0;
            col_q   <= 10'd0;
            ppr_q   <= 10'd1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            ppr_q   <= ppr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; dropping enable overrides everything and clears the scan position.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        plane_d    = plane_q;
        col_d      = col_q;
        ppr_d      = ppr_q;
        cnt_d      = cnt_q + 16'd1;
        frame_done = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            row_d   = 5'd0;
            plane_d = 3'd0;
            col_d   = 10'd0;
            cnt_d   = 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFetchT;
                    ppr_d   = ppr_clamp;
                    cnt_d   = 16'd0;
                end
                StFetchT: begin
                    state_d = StFetchB;
                    cnt_d   = 16'd0;
                end
                StFetchB: begin
                    state_d = StShiftL;
                    cnt_d   = 16'd0;
                end
                StShiftL: begin
                    if (last_cyc) begin
                        state_d = StShiftH;
                        cnt_d   = 16'd0;
                    end
                end
                StShiftH: begin
                    if (last_cyc) begin
                        cnt_d = 16'd0;
                        if (last_col) begin
                            state_d = StLatch;
                            col_d   = 10'd0;
                        end else begin
                            state_d = StFetchT;
                            col_d   = col_q + 10'd1;
                        end
                    end
                end
                StLatch: begin
                    if (last_cyc) begin
                        state_d = StShow;
                        cnt_d   = 16'd0;
                    end
                end
                StShow: begin
                    if (last_cyc) begin
                        state_d = StFetchT;
                        cnt_d   = 16'd0;
                        if (plane_q == 3'(PLANES - 1)) begin
                            plane_d = 3'd0;
                            row_d   = row_q + 5'd1;
                            if (row_q == 5'd31) begin
                                frame_done = 1'b1;
                                // New frame starts here: pick up any chain-length change.
                                ppr_d      = ppr_clamp;
                            end
                        end else begin
                            plane_d = plane_q + 3'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath: top word capture, colour pins, row address; all hold while disabled.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            top_q    <= 16'd0;
            hub_r1   <= 1'b0;
            hub_g1   <= 1'b0;
            hub_b1   <= 1'b0;
            hub_r2   <= 1'b0;
            hub_g2   <= 1'b0;
            hub_b2   <= 1'b0;
            hub_addr <= 5'd0;
        end else if (enable) begin
            if (state_q == StFetchB) begin
                top_q <= mem_rdata;
            end
            // Bottom word arrives now; it is consumed directly into the pins.
            if (state_q == StShiftL && cnt_q == 16'd0) begin
                hub_r1 <= top_q[r_idx];
                hub_g1 <= top_q[g_idx];
                hub_b1 <= top_q[b_idx];
                hub_r2 <= mem_rdata[r_idx];
                hub_g2 <= mem_rdata[g_idx];
                hub_b2 <= mem_rdata[b_idx];
            end
            if (state_q == StShiftH && last_cyc && last_col) begin
                hub_addr <= row_q;
            end
        end
    end

    // Panel strobes and read address decoded from the current state.
    always_comb begin
        mem_raddr = (state_q == StFetchB) ? {1'b1, row_q, col_q[8:0]} : {1'b0, row_q, col_q[8:0]};
        hub_clk   = (state_q == StShiftH);
        hub_lat   = (state_q == StLatch);
        hub_oe_n  = (state_q != StShow);
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_hub75_scan_gen.sv
// Directed bench for hub75_scan_gen with a one-cycle-latency RAM model.
module tb_hub75_scan_gen;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic        enable = 1'b0;
    logic [9:0]  pixels_per_row = 10'd4;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic [4:0]  hub_addr;
    logic        hub_clk, hub_lat, hub_oe_n, frame_done, busy;
    logic [5:0]  pins;
    int          errors = 0;
    int          checks = 0;
    int          ram_mode = 0;

    assign pins = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};

    always #5 pclk = ~pclk;

    hub75_scan_gen #(
        .CLK_DIV(2),
        .BASE_ON(8),
        .PLANES (5)
    ) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .enable        (enable),
        .pixels_per_row(pixels_per_row),
        .mem_raddr     (mem_raddr),
        .mem_rdata     (mem_rdata),
        .hub_r1        (hub_r1),
        .hub_g1        (hub_g1),
        .hub_b1        (hub_b1),
        .hub_r2        (hub_r2),
        .hub_g2        (hub_g2),
        .hub_b2        (hub_b2),
        .hub_addr      (hub_addr),
        .hub_clk       (hub_clk),
        .hub_lat       (hub_lat),
        .hub_oe_n      (hub_oe_n),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    // RAM model: mode 0 word = address ({row,col}); mode 1 red top / green bottom; mode 2 0x0001 top.
    always @(posedge pclk) begin
        case (ram_mode)
            0:       mem_rdata <= {1'b0, mem_raddr};
            1:       mem_rdata <= mem_raddr[14] ? 16'h07E0 : 16'hF800;
            default: mem_rdata <= mem_raddr[14] ? 16'h0000 : 16'h0001;
        endcase
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic restart(input logic [9:0] ppr, input int mode);
        enable = 1'b0;
        tick();
        tick();
        pixels_per_row = ppr;
        ram_mode = mode;
        enable = 1'b1;
        tick();
    endtask

    // Count hub_clk rising edges until hub_lat goes high; remember the last bottom-row address.
    task automatic count_row(output int rises, output logic [14:0] last_bot, output bit ok);
        logic prev_clk;
        int   guard;
        rises = 0;
        last_bot = 15'h0;
        prev_clk = hub_clk;
        guard = 0;
        while (hub_lat !== 1'b1 && guard < 4000) begin
            if (mem_raddr[14]) last_bot = mem_raddr;
            if (hub_clk && !prev_clk) rises++;
            prev_clk = hub_clk;
            tick();
            guard++;
        end
        ok = (hub_lat === 1'b1);
    endtask

    task automatic test_reset;
        enable = 1'b1;
        #3;
        presetn = 1'b0;
        repeat (3) tick();
        checks++;
        if (hub_oe_n !== 1'b1) begin
            errors++; $display("FAIL reset_oe_n: got %b want 1", hub_oe_n);
        end
        checks++;
        if (hub_lat !== 1'b0 || hub_clk !== 1'b0) begin
            errors++; $display("FAIL reset_lat_clk: got %b%b want 00", hub_lat, hub_clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (mem_raddr !== 15'h0) begin
            errors++; $display("FAIL reset_raddr: got %h want 0000", mem_raddr);
        end
        checks++;
        if (pins !== 6'b0 || hub_addr !== 5'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins: got pins=%b addr=%0d fd=%b want 0/0/0", pins, hub_addr,
                     frame_done);
        end
        enable = 1'b0;
        presetn = 1'b1;
        tick();
    endtask

    task automatic test_first_row;
        int          rises;
        int          nbot;
        int          guard;
        int          width;
        logic        prev_clk;
        logic [14:0] prev_addr;
        logic [5:0]  exp_pins;
        logic        c0;
        restart(10'd4, 0);
        rises = 0;
        nbot = 0;
        guard = 0;
        prev_clk = 1'b0;
        prev_addr = 15'h0;
        while (hub_lat !== 1'b1 && guard < 200) begin
            if (mem_raddr[14]) begin
                checks++;
                if (mem_raddr !== (15'h4000 | 15'(nbot)) || prev_addr !== 15'(nbot)) begin
                    errors++;
                    $display("FAIL first_row_raddr: got %h after %h want %h after %h", mem_raddr,
                             prev_addr, 15'h4000 | 15'(nbot), 15'(nbot));
                end
                nbot++;
            end
            if (hub_clk && !prev_clk) begin
                c0 = rises[0];
                exp_pins = {1'b0, 1'b0, c0, 1'b0, 1'b0, c0};
                checks++;
                if (pins !== exp_pins) begin
                    errors++;
                    $display("FAIL first_row_pins col %0d: got %b want %b", rises, pins, exp_pins);
                end
                rises++;
            end
            prev_clk = hub_clk;
            prev_addr = mem_raddr;
            tick();
            guard++;
        end
        checks++;
        if (rises != 4 || nbot != 4) begin
            errors++;
            $display("FAIL first_row_count: got clk=%0d fetch=%0d want 4/4", rises, nbot);
        end
        width = 0;
        while (hub_lat === 1'b1 && width < 50) begin
            width++;
            tick();
        end
        checks++;
        if (width != 2) begin
            errors++; $display("FAIL first_row_lat_width: got %0d want 2", width);
        end
        width = 0;
        while (hub_oe_n === 1'b0 && width < 50) begin
            width++;
            tick();
        end
        checks++;
        if (width != 8) begin
            errors++; $display("FAIL first_row_oe_width: got %0d want 8", width);
        end
        checks++;
        if (hub_addr !== 5'd0) begin
            errors++; $display("FAIL first_row_addr: got %0d want 0", hub_addr);
        end
    endtask

    task automatic test_plane_timing;
        int   guard;
        int   width;
        int   n;
        int   show_idx;
        logic prev_oe;
        restart(10'd4, 0);
        for (int p = 0; p < 5; p++) begin
            guard = 0;
            while (hub_oe_n !== 1'b0 && guard < 400) begin
                tick();
                guard++;
            end
            width = 0;
            while (hub_oe_n === 1'b0 && width < 400) begin
                width++;
                tick();
            end
            checks++;
            if (width != (8 << p)) begin
                errors++; $display("FAIL plane_oe_width p%0d: got %0d want %0d", p, width, 8 << p);
            end
        end
        guard = 0;
        while (frame_done !== 1'b1 && guard < 13000) begin
            tick();
            guard++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++; $display("FAIL frame_done_first: got %b want 1", frame_done);
        end
        tick();
        n = 1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_done_pulse: got %b want 0", frame_done);
        end
        show_idx = 0;
        prev_oe = 1'b1;
        while (frame_done !== 1'b1 && n < 13000) begin
            if (!hub_oe_n && prev_oe) begin
                if (show_idx % 5 == 0) begin
                    checks++;
                    if (hub_addr !== 5'(show_idx / 5)) begin
                        errors++;
                        $display("FAIL row_addr show %0d: got %0d want %0d", show_idx, hub_addr,
                                 show_idx / 5);
                    end
                end
                show_idx++;
            end
            prev_oe = hub_oe_n;
            tick();
            n++;
        end
        checks++;
        if (n != 12096) begin
            errors++; $display("FAIL frame_period: got %0d want 12096", n);
        end
        checks++;
        if (show_idx != 160) begin
            errors++; $display("FAIL frame_shows: got %0d want 160", show_idx);
        end
    endtask

    task automatic test_bit_select;
        int         guard;
        logic [5:0] exp_pins;
        for (int m = 1; m <= 2; m++) begin
            restart(10'd1, m);
            for (int p = 0; p < 5; p++) begin
                guard = 0;
                while (hub_clk !== 1'b1 && guard < 400) begin
                    tick();
                    guard++;
                end
                if (m == 1) exp_pins = 6'b100010;
                else exp_pins = (p == 0) ? 6'b001000 : 6'b000000;
                checks++;
                if (hub_clk !== 1'b1 || pins !== exp_pins) begin
                    errors++;
                    $display("FAIL bit_select m%0d p%0d: got clk=%b pins=%b want clk=1 pins=%b",
                             m, p, hub_clk, pins, exp_pins);
                end
                guard = 0;
                while (hub_clk !== 1'b0 && guard < 50) begin
                    tick();
                    guard++;
                end
            end
        end
    endtask

    task automatic test_clamp;
        int          rises;
        logic [14:0] last_bot;
        bit          ok;
        restart(10'd0, 0);
        count_row(rises, last_bot, ok);
        checks++;
        if (!ok || rises != 1) begin
            errors++; $display("FAIL clamp_low: got ok=%0d clk=%0d want 1/1", ok, rises);
        end
        restart(10'd700, 0);
        count_row(rises, last_bot, ok);
        checks++;
        if (!ok || rises != 512) begin
            errors++; $display("FAIL clamp_high: got ok=%0d clk=%0d want 1/512", ok, rises);
        end
        checks++;
        if (last_bot !== 15'h41FF) begin
            errors++; $display("FAIL clamp_last_raddr: got %h want 41ff", last_bot);
        end
    endtask

    task automatic test_enable_drop;
        int          lats;
        int          guard;
        int          rises;
        logic        prev_lat;
        logic [14:0] last_bot;
        bit          ok;
        restart(10'd4, 0);
        lats = 0;
        guard = 0;
        prev_lat = 1'b0;
        while (lats < 25 && guard < 3000) begin
            if (hub_lat && !prev_lat) lats++;
            prev_lat = hub_lat;
            tick();
            guard++;
        end
        guard = 0;
        while (hub_clk !== 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        enable = 1'b0;
        tick();
        checks++;
        if (hub_oe_n !== 1'b1 || hub_clk !== 1'b0 || hub_lat !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got oe_n=%b clk=%b lat=%b busy=%b want 1/0/0/0", hub_oe_n,
                     hub_clk, hub_lat, busy);
        end
        // Row 5 col 0 plane 0: top 0x0A00, bottom 0x4A00 -> only R bits set.
        checks++;
        if (pins !== 6'b100100 || hub_addr !== 5'd4) begin
            errors++;
            $display("FAIL drop_hold: got pins=%b addr=%0d want 100100/4", pins, hub_addr);
        end
        tick();
        tick();
        enable = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || mem_raddr !== 15'h0) begin
            errors++;
            $display("FAIL reenable_raddr: got busy=%b raddr=%h want 1/0000", busy, mem_raddr);
        end
        pixels_per_row = 10'd2;
        count_row(rises, last_bot, ok);
        checks++;
        if (!ok || rises != 4 || hub_addr !== 5'd0) begin
            errors++;
            $display("FAIL reenable_row0: got ok=%0d clk=%0d addr=%0d want 1/4/0", ok, rises,
                     hub_addr);
        end
        guard = 0;
        while (frame_done !== 1'b1 && guard < 13000) begin
            tick();
            guard++;
        end
        count_row(rises, last_bot, ok);
        checks++;
        if (!ok || rises != 2) begin
            errors++; $display("FAIL ppr_next_frame: got ok=%0d clk=%0d want 1/2", ok, rises);
        end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_plane_timing();
        test_bit_select();
        test_clamp();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
